// File: rtl/s_block_writer.sv
// -----------------------------------------------------------------------------
// s_block_writer
//
// Output stage of the IDCT datapath. It reads a finished 8x8 S block
// (signed 32-bit fixed point, DP-RAM addresses 64..127) through both RAM
// ports, one horizontal pixel pair per cycle. Each entry becomes an 8-bit
// pixel by taking S[23:16] and clamping to 0..255. Each pair is packed into
// one 16-bit word and written to the SRAM frame buffer at the selected
// block position.
//
// Ports
//   CLOCK_50_I       : 50 MHz clock, single domain
//   Reset            : asynchronous active-high reset
//   WB_start         : one-cycle start request, honoured only in IDLE
//   WB_done          : one-cycle pulse after the last SRAM write
//   block_row/col    : block position (0..29 / 0..39), latched at start
//   S_read_address   : DP-RAM addresses, [0] = even column, [1] = odd column
//   S_read_data      : DP-RAM data, valid one cycle after the address
//   S_write_enable   : tied low, this block only reads the RAM
//   SRAM_address     : SRAM word address
//   SRAM_write_data  : {even-column pixel, odd-column pixel}
//   SRAM_we_n        : SRAM write enable, active low
// -----------------------------------------------------------------------------
module s_block_writer #(
    parameter logic [17:0] Y_BASE    = 18'd0,
    parameter int          ROW_WORDS = 160
) (
    input  logic            CLOCK_50_I,
    input  logic            Reset,
    input  logic            WB_start,
    output logic            WB_done,
    input  logic [4:0]      block_row,
    input  logic [5:0]      block_col,
    output logic [1:0][6:0] S_read_address,
    input  logic [1:0][31:0] S_read_data,
    output logic [1:0]      S_write_enable,
    output logic [17:0]     SRAM_address,
    output logic [15:0]     SRAM_write_data,
    output logic            SRAM_we_n
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_LO_0 = 2'd2;
    localparam logic [1:0] S_LO_1 = 2'd3;

    logic [1:0]  state;
    logic [4:0]  p;          // pair counter: p[4:2] = block row, p[1:0] = packed column
    logic [4:0]  row_q;
    logic [5:0]  col_q;

    // Read-return stage: marks the cycle in which S_read_data belongs to pair rd_p.
    logic        rd_valid;
    logic [4:0]  rd_p;

    logic [17:0] wr_addr;
    logic [15:0] wr_data;

    // S value to pixel: negative -> 0, integer part above 255 -> 255,
    // otherwise the integer byte. The fraction is truncated.
    function automatic logic [7:0] to_pixel(input logic [31:0] s);
        if (s[31])
            return 8'd0;
        else if (s[30:24] != 7'd0)
            return 8'hFF;
        else
            return s[23:16];
    endfunction

    assign S_write_enable = 2'b00;

    // NOTE: every signal assigned in an always_comb gets a value on every path
    // (defaults first), otherwise synthesis infers a latch.
    always_comb begin
        S_read_address = '0;
        if (state == S_RUN) begin
            // 64 + 2p and 65 + 2p, built by concatenation.
            S_read_address[0] = {1'b1, p, 1'b0};
            S_read_address[1] = {1'b1, p, 1'b1};
        end
    end

    // {row_q, r} = block_row*8 + r and {col_q, c} = block_col*4 + c, both
    // exact. The product is formed at 18 bits, which holds the maximum 38399.
    always_comb begin
        wr_addr = Y_BASE
                + 18'({row_q, rd_p[4:2]}) * 18'(ROW_WORDS)
                + 18'({col_q, rd_p[1:0]});
        wr_data = {to_pixel(S_read_data[0]), to_pixel(S_read_data[1])};
    end

    // NOTE: sequential state uses non-blocking assignments so that every
    // register samples the values from before the clock edge.
    always_ff @(posedge CLOCK_50_I or posedge Reset) begin
        if (Reset) begin
            state   <= S_IDLE;
            p       <= 5'd0;
            row_q   <= 5'd0;
            col_q   <= 6'd0;
            WB_done <= 1'b0;
        end else begin
            WB_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (WB_start) begin
                        row_q <= block_row;
                        col_q <= block_col;
                        p     <= 5'd0;
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    p <= p + 5'd1;
                    if (p == 5'd31)
                        state <= S_LO_0;
                end
                S_LO_0: state <= S_LO_1;
                S_LO_1: begin
                    state   <= S_IDLE;
                    WB_done <= 1'b1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // p travels with the read so the write address matches the returning data.
    always_ff @(posedge CLOCK_50_I or posedge Reset) begin
        if (Reset) begin
            rd_valid <= 1'b0;
            rd_p     <= 5'd0;
        end else begin
            rd_valid <= (state == S_RUN);
            rd_p     <= p;
        end
    end

    // SRAM output register. Address and data hold their last values between writes.
    always_ff @(posedge CLOCK_50_I or posedge Reset) begin
        if (Reset) begin
            SRAM_we_n       <= 1'b1;
            SRAM_address    <= 18'd0;
            SRAM_write_data <= 16'd0;
        end else begin
            SRAM_we_n <= ~rd_valid;
            if (rd_valid) begin
                SRAM_address    <= wr_addr;
                SRAM_write_data <= wr_data;
            end
        end
    end

endmodule

// File: tb/tb_s_block_writer.sv
// -----------------------------------------------------------------------------
// tb_s_block_writer
//
// Directed bench for s_block_writer. A behavioural DP-RAM with one-cycle read
// latency feeds the DUT. A negedge monitor logs every SRAM write and every
// WB_done pulse with its cycle number. Each step checks the log against
// hand-computed values and a small address/pixel reference model.
// -----------------------------------------------------------------------------
module tb_s_block_writer;

    logic             CLOCK_50_I = 1'b0;
    logic             Reset      = 1'b1;
    logic             WB_start   = 1'b0;
    logic             WB_done;
    logic [4:0]       block_row  = 5'd0;
    logic [5:0]       block_col  = 6'd0;
    logic [1:0][6:0]  S_read_address;
    logic [1:0][31:0] S_read_data;
    logic [1:0]       S_write_enable;
    logic [17:0]      SRAM_address;
    logic [15:0]      SRAM_write_data;
    logic             SRAM_we_n;

    logic [31:0] ram [0:127];

    int n_cmp  = 0;
    int n_err  = 0;
    int cyc    = 0;
    int wr_n   = 0;
    int done_n = 0;
    int wr_cyc  [512];
    int wr_addr [512];
    int wr_data [512];
    int done_cyc[64];

    s_block_writer #(.Y_BASE(18'd0), .ROW_WORDS(160)) dut (
        .CLOCK_50_I      (CLOCK_50_I),
        .Reset           (Reset),
        .WB_start        (WB_start),
        .WB_done         (WB_done),
        .block_row       (block_row),
        .block_col       (block_col),
        .S_read_address  (S_read_address),
        .S_read_data     (S_read_data),
        .S_write_enable  (S_write_enable),
        .SRAM_address    (SRAM_address),
        .SRAM_write_data (SRAM_write_data),
        .SRAM_we_n       (SRAM_we_n)
    );

    always #10 CLOCK_50_I = ~CLOCK_50_I;

    // Cycle counter and two-port RAM with registered read data.
    always @(posedge CLOCK_50_I) begin
        cyc            <= cyc + 1;
        S_read_data[0] <= ram[S_read_address[0]];
        S_read_data[1] <= ram[S_read_address[1]];
    end

    // Write/done logger, sampled on the inactive edge.
    always @(negedge CLOCK_50_I) begin
        if (SRAM_we_n === 1'b0 && wr_n < 512) begin
            wr_cyc[wr_n]  = cyc;
            wr_addr[wr_n] = int'(SRAM_address);
            wr_data[wr_n] = int'(SRAM_write_data);
            wr_n          = wr_n + 1;
        end
        if (WB_done === 1'b1 && done_n < 64) begin
            done_cyc[done_n] = cyc;
            done_n           = done_n + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge CLOCK_50_I);
        #1;
    endtask

    function automatic int ref_pixel(input logic [31:0] s);
        if (s[31])                 return 0;
        if (s >= 32'h0100_0000)    return 255;
        return int'(s >> 16);
    endfunction

    function automatic int ref_addr(input int row, input int col, input int k);
        return (row * 8 + k / 4) * 160 + col * 4 + k % 4;
    endfunction

    // Issue a start in the current cycle (cycle 0); returns in cycle 1.
    task automatic start_block(input int row, input int col, output int s0, output int w0, output int d0);
        block_row = 5'(row);
        block_col = 6'(col);
        WB_start  = 1'b1;
        s0 = cyc;
        w0 = wr_n;
        d0 = done_n;
        tick();
        WB_start = 1'b0;
    endtask

    task automatic wait_done(input int d0, input string tag);
        int n = 0;
        while (done_n == d0 && n < 80) begin
            tick();
            n++;
        end
        check({tag, " done seen"}, 32'(done_n > d0), 32'd1);
    endtask

    // Checks all 32 writes of one block (timing, address, packed data).
    task automatic check_block(input string tag, input int s0, input int w0, input int row, input int col);
        for (int k = 0; k < 32; k++) begin
            check($sformatf("%s cyc %0d", tag, k),  32'(wr_cyc[w0 + k]),  32'(s0 + 3 + k));
            check($sformatf("%s addr %0d", tag, k), 32'(wr_addr[w0 + k]), 32'(ref_addr(row, col, k)));
            check($sformatf("%s data %0d", tag, k), 32'(wr_data[w0 + k]),
                  32'(ref_pixel(ram[64 + 2 * k]) * 256 + ref_pixel(ram[65 + 2 * k])));
        end
    endtask

    initial begin
        int s0, w0, d0, s1;

        for (int i = 0; i < 128; i++) ram[i] = 32'd0;

        // ---- Reset then idle ----
        repeat (3) tick();
        check("rst we_n",   32'(SRAM_we_n), 32'd1);
        check("rst done",   32'(WB_done), 32'd0);
        Reset = 1'b0;
        tick();
        check("idle addr",  32'(SRAM_address), 32'd0);
        check("idle data",  32'(SRAM_write_data), 32'd0);
        check("idle rd0",   32'(S_read_address[0]), 32'd0);
        check("idle rd1",   32'(S_read_address[1]), 32'd0);
        check("idle s_we",  32'(S_write_enable), 32'd0);
        w0 = wr_n;
        repeat (100) tick();
        check("idle no writes", 32'(wr_n - w0), 32'd0);
        check("idle no done",   32'(done_n), 32'd0);

        // ---- Ramp block ----
        for (int i = 0; i < 64; i++) ram[64 + i] = 32'(i) << 16;
        start_block(0, 0, s0, w0, d0);
        wait_done(d0, "ramp");
        check("ramp done cycle", 32'(done_cyc[d0]), 32'(s0 + 35));
        check("ramp count",      32'(wr_n - w0), 32'd32);
        check("ramp w0 addr",    32'(wr_addr[w0]), 32'd0);
        check("ramp w0 data",    32'(wr_data[w0]), 32'h0001);
        check("ramp w3 addr",    32'(wr_addr[w0 + 3]), 32'd3);
        check("ramp w3 data",    32'(wr_data[w0 + 3]), 32'h0607);
        check("ramp w4 addr",    32'(wr_addr[w0 + 4]), 32'd160);
        check("ramp w4 data",    32'(wr_data[w0 + 4]), 32'h0809);
        check("ramp w31 addr",   32'(wr_addr[w0 + 31]), 32'd1123);
        check("ramp w31 data",   32'(wr_data[w0 + 31]), 32'h3E3F);
        check_block("ramp", s0, w0, 0, 0);
        repeat (3) tick();
        check("ramp single done", 32'(done_n - d0), 32'd1);
        check("ramp hold addr",   32'(SRAM_address), 32'd1123);

        // ---- Saturation ----
        ram[64] = 32'hFFFF_0000;
        ram[65] = 32'h0100_0000;
        ram[66] = 32'h0080_1234;
        ram[67] = 32'h00FF_FFFF;
        start_block(0, 0, s0, w0, d0);
        wait_done(d0, "sat");
        check("sat w0 data", 32'(wr_data[w0]), 32'h00FF);
        check("sat w1 data", 32'(wr_data[w0 + 1]), 32'h80FF);
        check_block("sat", s0, w0, 0, 0);

        // ---- Corner block ----
        start_block(29, 39, s0, w0, d0);
        wait_done(d0, "corner");
        check("corner first addr", 32'(wr_addr[w0]), 32'd37276);
        check("corner w3 addr",    32'(wr_addr[w0 + 3]), 32'd37279);
        check("corner last addr",  32'(wr_addr[w0 + 31]), 32'd38399);
        check_block("corner", s0, w0, 29, 39);

        // ---- Ignored start, then back-to-back ----
        start_block(1, 2, s0, w0, d0);        // now in cycle 1
        repeat (9) tick();                    // cycle 10
        block_row = 5'd3;
        block_col = 6'd5;
        WB_start  = 1'b1;
        tick();
        WB_start  = 1'b0;
        repeat (24) tick();                   // cycle 35
        check("b2b done at 35", 32'(WB_done), 32'd1);
        start_block(3, 5, s1, d0, d0);        // start in cycle 35
        d0 = done_n - 1;
        begin
            int n = 0;
            while (done_n < d0 + 2 && n < 80) begin
                tick();
                n++;
            end
        end
        check("b2b done count",  32'(done_n - d0), 32'd2);
        check("b2b done1 cycle", 32'(done_cyc[d0]), 32'(s0 + 35));
        check("b2b done2 cycle", 32'(done_cyc[d0 + 1]), 32'(s0 + 70));
        check("b2b write count", 32'(wr_n - w0), 32'd64);
        check("b2b B first cyc", 32'(wr_cyc[w0 + 32]), 32'(s0 + 38));
        check("b2b A first addr", 32'(wr_addr[w0]), 32'd1288);
        check("b2b B first addr", 32'(wr_addr[w0 + 32]), 32'd3860);
        check_block("b2bA", s0, w0, 1, 2);
        check_block("b2bB", s1, w0 + 32, 3, 5);

        // ---- Reset mid-block ----
        start_block(2, 3, s0, w0, d0);        // cycle 1
        repeat (11) tick();                   // cycle 12
        Reset = 1'b1;
        #1;
        check("midrst we_n async", 32'(SRAM_we_n), 32'd1);
        check("midrst done",       32'(WB_done), 32'd0);
        repeat (2) tick();
        Reset = 1'b0;
        repeat (50) tick();
        check("midrst writes", 32'(wr_n - w0), 32'd10);
        check("midrst no done", 32'(done_n - d0), 32'd0);
        start_block(2, 3, s0, w0, d0);
        wait_done(d0, "restart");
        check("restart count",      32'(wr_n - w0), 32'd32);
        check("restart first addr", 32'(wr_addr[w0]), 32'd2572);
        check_block("restart", s0, w0, 2, 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
